fir_interp: RTL and testbench

- Polyphase interpolating FIR for the FM radio chain; the counterpart to the decimating fir_top.
- Pops one sample per input from an upstream show-ahead FIFO (x_in_*) and writes INTERPOLATION filtered samples per input to a downstream FIFO (y_out_*).
- Sits between an audio-rate stage and a higher-rate consumer; one multiplier, one MAC per cycle.

---
 rtl/fir_interp.sv | 132 +++++++++++++
 tb/tb_fir_interp.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input popped, INTERPOLATION filtered outputs written.
// A single multiplier runs one tap per cycle for each phase in turn.
module fir_interp #(
    parameter int unsigned TAPS          = 32,
    parameter int unsigned INTERPOLATION = 4,
    parameter int unsigned DATA_SIZE     = 32,
    parameter int unsigned BITS          = 10,
    parameter logic signed [DATA_SIZE-1:0] COEFFS [0:TAPS-1] = '{default: '0}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 x_in_empty,
    output logic                 x_in_rd_en,
    input  logic [DATA_SIZE-1:0] x_in_dout,
    input  logic                 y_out_full,
    output logic                 y_out_wr_en,
    output logic [DATA_SIZE-1:0] y_out_din
);

    localparam int unsigned TapsPerPhase = TAPS / INTERPOLATION;
    localparam int unsigned TapW   = (TapsPerPhase > 1) ? $clog2(TapsPerPhase) : 1;
    localparam int unsigned PhaseW = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
    localparam int unsigned IdxW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TapW-1:0]   MLast = TapW'(TapsPerPhase - 1);
    localparam logic [PhaseW-1:0] PLast = PhaseW'(INTERPOLATION - 1);
    localparam logic signed [2*DATA_SIZE-1:0] RndAdd = (2*DATA_SIZE)'(2**BITS - 1);

    typedef enum logic [1:0] {StIdle, StMac, StWrite} state_e;

    state_e                      state_q, state_d;
    logic [PhaseW-1:0]           p_q, p_d;
    logic [TapW-1:0]             m_q, m_d;
    logic [DATA_SIZE-1:0]        acc_q, acc_d;
    logic signed [DATA_SIZE-1:0] x_hist_q [0:TapsPerPhase-1];
    logic signed [DATA_SIZE-1:0] x_hist_d [0:TapsPerPhase-1];
    logic                        y_out_wr_en_q, y_out_wr_en_d;
    logic [DATA_SIZE-1:0]        y_out_din_q, y_out_din_d;

    logic [IdxW-1:0]             h_idx;
    logic signed [DATA_SIZE-1:0] coef, xs;
    logic signed [2*DATA_SIZE-1:0] prod, prod_adj;
    logic [DATA_SIZE-1:0]        deq, acc_sum;

    // Bias negative products so the arithmetic shift truncates toward zero.
    always_comb begin
        h_idx    = IdxW'(p_q) + IdxW'(m_q) * IdxW'(INTERPOLATION);
        coef     = COEFFS[h_idx];
        xs       = x_hist_q[m_q];
        prod     = $signed({{DATA_SIZE{coef[DATA_SIZE-1]}}, coef})
                 * $signed({{DATA_SIZE{xs[DATA_SIZE-1]}}, xs});
        prod_adj = prod + (prod[2*DATA_SIZE-1] ? RndAdd : '0);
        deq      = DATA_SIZE'(prod_adj >>> BITS);
        acc_sum  = acc_q + deq;
    end

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        m_d           = m_q;
        acc_d         = acc_q;
        x_hist_d      = x_hist_q;
        y_out_wr_en_d = 1'b0;
        y_out_din_d   = y_out_din_q;
        x_in_rd_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!x_in_empty) begin
                    x_in_rd_en  = 1'b1;
                    x_hist_d[0] = x_in_dout;
                    for (int i = 1; i < TapsPerPhase; i++) x_hist_d[i] = x_hist_q[i-1];
                    p_d     = '0;
                    m_d     = '0;
                    acc_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_sum;
                m_d   = m_q + TapW'(1);
                // The strobe is registered, so the write is launched from the last tap.
                if (m_q == MLast) begin
                    m_d     = '0;
                    state_d = StWrite;
                    if (!y_out_full) begin
                        y_out_wr_en_d = 1'b1;
                        y_out_din_d   = acc_sum;
                    end
                end
            end
            StWrite: begin
                if (y_out_wr_en_q) begin
                    if (p_q == PLast) begin
                        state_d = StIdle;
                    end else begin
                        p_d     = p_q + PhaseW'(1);
                        m_d     = '0;
                        acc_d   = '0;
                        state_d = StMac;
                    end
                end else if (!y_out_full) begin
                    y_out_wr_en_d = 1'b1;
                    y_out_din_d   = acc_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            p_q           <= '0;
            m_q           <= '0;
            acc_q         <= '0;
            y_out_wr_en_q <= 1'b0;
            y_out_din_q   <= '0;
            for (int i = 0; i < TapsPerPhase; i++) x_hist_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            m_q           <= m_d;
            acc_q         <= acc_d;
            y_out_wr_en_q <= y_out_wr_en_d;
            y_out_din_q   <= y_out_din_d;
            x_hist_q      <= x_hist_d;
        end
    end

    assign y_out_wr_en = y_out_wr_en_q;
    assign y_out_din   = y_out_din_q;

endmodule

// File: tb/tb_fir_interp.sv
// Directed bench for fir_interp: three instances (impulse, rounding, timing) driven from
// bench-side FIFO models, with writes and pops recorded every cycle.
module tb_fir_interp;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    localparam logic signed [31:0] HImp [0:7]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    localparam logic signed [31:0] HRnd [0:3]  = '{32'sh400, 1, 0, 0};
    localparam logic signed [31:0] HCyc [0:31] = '{default: 32'sh400};

    logic        x_empty [3];
    logic        x_rd    [3];
    logic [31:0] x_dout  [3];
    logic        y_full  [3];
    logic        y_wr    [3];
    logic [31:0] y_din   [3];

    fir_interp #(.TAPS(8), .INTERPOLATION(2), .DATA_SIZE(32), .BITS(0), .COEFFS(HImp)) u_imp (
        .clock(clock), .reset(reset), .x_in_empty(x_empty[0]), .x_in_rd_en(x_rd[0]),
        .x_in_dout(x_dout[0]), .y_out_full(y_full[0]), .y_out_wr_en(y_wr[0]),
        .y_out_din(y_din[0])
    );
    fir_interp #(.TAPS(4), .INTERPOLATION(2), .DATA_SIZE(32), .BITS(10), .COEFFS(HRnd)) u_rnd (
        .clock(clock), .reset(reset), .x_in_empty(x_empty[1]), .x_in_rd_en(x_rd[1]),
        .x_in_dout(x_dout[1]), .y_out_full(y_full[1]), .y_out_wr_en(y_wr[1]),
        .y_out_din(y_din[1])
    );
    fir_interp #(.TAPS(32), .INTERPOLATION(4), .DATA_SIZE(32), .BITS(10), .COEFFS(HCyc)) u_cyc (
        .clock(clock), .reset(reset), .x_in_empty(x_empty[2]), .x_in_rd_en(x_rd[2]),
        .x_in_dout(x_dout[2]), .y_out_full(y_full[2]), .y_out_wr_en(y_wr[2]),
        .y_out_din(y_din[2])
    );

    int got     [3][128];
    int wr_cyc  [3][128];
    int pop_cyc [3][16];
    int got_n   [3];
    int pop_n   [3];
    int src     [3][64];
    int src_n   [3];
    int src_rd  [3];
    bit gap     [3];
    bit full_prev [3];
    bit rand_gap;
    int viol;
    int cyc;
    int checks;
    int errors;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            x_empty[i] = gap[i] || (src_rd[i] >= src_n[i]);
            x_dout[i]  = (src_rd[i] < src_n[i]) ? src[i][src_rd[i]] : 32'd0;
        end
    endtask

    task automatic clear(input int i);
        got_n[i]  = 0;
        pop_n[i]  = 0;
        src_n[i]  = 0;
        src_rd[i] = 0;
        drive();
    endtask

    task automatic load(input int i, input int v);
        src[i][src_n[i]] = v;
        src_n[i]++;
        drive();
    endtask

    // Sample this cycle's outputs late in the cycle, then advance one clock.
    task automatic tick();
        bit popped [3];
        #1;
        for (int i = 0; i < 3; i++) begin
            popped[i] = x_rd[i];
            if (x_rd[i]) begin
                if (x_empty[i]) viol++;
                if (pop_n[i] < 16) pop_cyc[i][pop_n[i]] = cyc;
                pop_n[i]++;
            end
            if (y_wr[i]) begin
                if (full_prev[i]) viol++;
                if (got_n[i] < 128) begin
                    got[i][got_n[i]]    = y_din[i];
                    wr_cyc[i][got_n[i]] = cyc;
                end
                got_n[i]++;
            end
            full_prev[i] = y_full[i];
        end
        @(posedge clock);
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) if (popped[i]) src_rd[i]++;
        if (rand_gap) gap[0] = ($urandom_range(0, 1) == 1);
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    int hist [4];
    int exp_y [24];
    int xv;

    initial begin
        checks   = 0;
        errors   = 0;
        viol     = 0;
        cyc      = 0;
        rand_gap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            y_full[i]    = 1'b0;
            gap[i]       = 1'b1;
            full_prev[i] = 1'b0;
            clear(i);
        end
        run(3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_wr_en[%0d]", i), y_wr[i], 0);
            check($sformatf("reset_din[%0d]", i), y_din[i], 0);
            check($sformatf("reset_rd_en[%0d]", i), x_rd[i], 0);
        end
        reset = 1'b1;

        // Impulse through TAPS=8, L=2 gives the coefficients back in order.
        gap[0] = 1'b0;
        load(0, 1); load(0, 0); load(0, 0); load(0, 0);
        run(80);
        check("impulse_writes", got_n[0], 8);
        check("impulse_pops", pop_n[0], 4);
        for (int k = 0; k < 8; k++) check($sformatf("impulse_y[%0d]", k), got[0][k], k + 1);

        // Truncation toward zero: deq(-1) is 0, deq(-3000) is -2.
        gap[1] = 1'b0;
        load(1, -1); load(1, 32'h7FF); load(1, -3000);
        run(60);
        check("round_writes", got_n[1], 6);
        check("round_y0", got[1][0], -1);
        check("round_y1", got[1][1], 0);
        check("round_y2", got[1][2], 2047);
        check("round_y3", got[1][3], 1);
        check("round_y4", got[1][4], -3000);
        check("round_y5", got[1][5], -2);

        // Backpressure: full held across the first write point, then released.
        clear(0);
        y_full[0] = 1'b1;
        load(0, 1); load(0, 0); load(0, 0); load(0, 0);
        run(15);
        check("stall_no_writes", got_n[0], 0);
        check("stall_din_held", y_din[0], 8);
        y_full[0] = 1'b0;
        run(80);
        check("stall_writes", got_n[0], 8);
        for (int k = 0; k < 8; k++) check($sformatf("stall_y[%0d]", k), got[0][k], k + 1);

        // Random upstream gaps; history carries the previous impulse (newest first).
        clear(0);
        hist = '{0, 0, 0, 1};
        for (int n = 0; n < 12; n++) begin
            xv = int'($urandom_range(0, 400)) - 200;
            load(0, xv);
            for (int m = 3; m > 0; m--) hist[m] = hist[m-1];
            hist[0] = xv;
            for (int p = 0; p < 2; p++) begin
                exp_y[2*n+p] = 0;
                for (int m = 0; m < 4; m++) exp_y[2*n+p] += int'(HImp[p+2*m]) * hist[m];
            end
        end
        rand_gap = 1'b1;
        run(400);
        rand_gap = 1'b0;
        gap[0]   = 1'b0;
        drive();
        check("gaps_writes", got_n[0], 24);
        check("gaps_pops", pop_n[0], 12);
        for (int k = 0; k < 24; k++) check($sformatf("gaps_y[%0d]", k), got[0][k], exp_y[k]);

        // Reset during the MAC of the second input, then a clean impulse.
        clear(0);
        load(0, 5); load(0, 7);
        for (int k = 0; k < 60 && pop_n[0] < 2; k++) tick();
        check("mid_second_pop", pop_n[0], 2);
        run(2);
        gap[0] = 1'b1;
        drive();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_wr_en", y_wr[0], 0);
        check("mid_rst_din", y_din[0], 0);
        check("mid_rst_rd_en", x_rd[0], 0);
        check("mid_rst_din_rnd", y_din[1], 0);
        @(posedge clock);
        #1;
        run(2);
        reset = 1'b1;
        clear(0);
        gap[0] = 1'b0;
        load(0, 1); load(0, 0); load(0, 0); load(0, 0);
        run(80);
        check("post_rst_writes", got_n[0], 8);
        for (int k = 0; k < 8; k++) check($sformatf("post_rst_y[%0d]", k), got[0][k], k + 1);

        // Timing with TAPS=32, L=4 and unit coefficients (output = sum of last 8 inputs).
        gap[2] = 1'b0;
        for (int n = 1; n <= 10; n++) load(2, n);
        run(450);
        check("cyc_writes", got_n[2], 40);
        check("cyc_pops", pop_n[2], 10);
        check("cyc_first_latency", wr_cyc[2][0] - pop_cyc[2][0], 9);
        check("cyc_pop_spacing_0", pop_cyc[2][1] - pop_cyc[2][0], 37);
        check("cyc_pop_spacing_8", pop_cyc[2][9] - pop_cyc[2][8], 37);
        check("cyc_y0", got[2][0], 1);
        check("cyc_y4", got[2][4], 3);
        check("cyc_y36", got[2][36], 52);
        check("cyc_y39", got[2][39], 52);

        check("protocol_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
